// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: shares the Bridge port between the zero-latency CPU and a
// req/ack DMA master served only in CPU-idle cycles, with window, starvation and grant counting.
module bus_master_arbiter #(
  parameter logic [31:0] DMA_ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] DMA_ADDR_HI = 32'h0000_FFFF,
  parameter int          MAX_WAIT    = 16,
  parameter int          CNT_W       = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst_n,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  input  logic             dma_req,
  input  logic [31:0]      dma_addr,
  input  logic             dma_we,
  input  logic [31:0]      dma_wdata,
  output logic [31:0]      dma_rdata,
  output logic             dma_ack,
  output logic             dma_err,
  output logic             dma_gnt,
  output logic             dma_starve,
  output logic [CNT_W-1:0] gnt_cnt,
  output logic [31:0]      bus_addr,
  output logic             bus_we,
  output logic [31:0]      bus_wdata,
  input  logic [31:0]      bus_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic in_win, set_starve;
  // Offset form of the range check stays correct when DMA_ADDR_LO is zero
  assign in_win = (dma_addr - DMA_ADDR_LO) <= (DMA_ADDR_HI - DMA_ADDR_LO);
  assign dma_gnt = (state != ACK) && dma_req && !cpu_req && in_win;
  assign dma_ack = (state == ACK);
  assign cpu_rdata = bus_rdata;
  assign bus_addr = dma_gnt ? dma_addr : cpu_addr;
  assign bus_wdata = dma_gnt ? dma_wdata : cpu_wdata;
  assign bus_we = dma_gnt ? dma_we : (cpu_we & cpu_req);
  always_comb begin
    state_nxt = IDLE;
    if (state != ACK && dma_req)
      state_nxt = (!in_win || !cpu_req) ? ACK : WAIT;
    wait_nxt = (state_nxt != WAIT) ? '0 :
               (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
    set_starve = (state_nxt == WAIT) && (wait_nxt == WW'(MAX_WAIT));
  end
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      dma_rdata  <= '0;
      dma_err    <= 1'b0;
      dma_starve <= 1'b0;
      gnt_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      dma_err  <= (state != ACK) && dma_req && !in_win;
      if (dma_gnt && !dma_we) dma_rdata <= bus_rdata;
      if (dma_gnt) gnt_cnt <= gnt_cnt + 1'b1;
      if (set_starve) dma_starve <= 1'b1;
      else if (dma_ack && !dma_err) dma_starve <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter: directed vectors against a word-addressed DRAM model on the bus port.
module tb_bus_master_arbiter;
  logic cpu_clk = 0, cpu_rst_n = 0;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [31:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata, bus_rdata;
  logic dma_ack, dma_err, dma_gnt, dma_starve, bus_we;
  logic [15:0] gnt_cnt;
  logic [31:0] mem [0:1023];
  int checks = 0, errors = 0;

  bus_master_arbiter #(.MAX_WAIT(4)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err), .dma_gnt(dma_gnt),
    .dma_starve(dma_starve), .gnt_cnt(gnt_cnt),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;
  assign bus_rdata = mem[bus_addr[11:2]];
  always @(posedge cpu_clk) if (bus_we) mem[bus_addr[11:2]] <= bus_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[32'h40 >> 2] = 32'h1234_5678;
    mem[32'hFFFC >> 2 & 1023] = 32'h0BAD_F00D;
    #12;
    chk("rst_ack", {31'b0, dma_ack}, 0);
    chk("rst_err", {31'b0, dma_err}, 0);
    chk("rst_starve", {31'b0, dma_starve}, 0);
    chk("rst_cnt", {16'b0, gnt_cnt}, 0);
    chk("rst_rdata", dma_rdata, 0);
    cpu_rst_n = 1;
    step;
    cpu_req = 1; cpu_addr = 32'h100; cpu_we = 1; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("cpu_addr", bus_addr, 32'h100);
    chk("cpu_we", {31'b0, bus_we}, 1);
    chk("cpu_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("cpu_gnt", {31'b0, dma_gnt}, 0);
    step;
    cpu_req = 0; cpu_we = 0;
    #1;
    chk("cpu_mem", mem[32'h100 >> 2], 32'hDEAD_BEEF);
    chk("cpu_cnt", {16'b0, gnt_cnt}, 0);
    chk("idle_we", {31'b0, bus_we}, 0);
    cpu_we = 1;
    #1;
    chk("idle_we_noreq", {31'b0, bus_we}, 0);
    cpu_we = 0;
    dma_req = 1; dma_addr = 32'h40; dma_we = 0;
    #1;
    chk("rd_gnt", {31'b0, dma_gnt}, 1);
    chk("rd_bus_addr", bus_addr, 32'h40);
    step;
    chk("rd_ack", {31'b0, dma_ack}, 1);
    chk("rd_rdata", dma_rdata, 32'h1234_5678);
    chk("rd_err", {31'b0, dma_err}, 0);
    chk("rd_cnt", {16'b0, gnt_cnt}, 1);
    chk("rd_ack_gnt", {31'b0, dma_gnt}, 0);
    dma_req = 0;
    step;
    chk("rd_ack_once", {31'b0, dma_ack}, 0);
    cpu_req = 1; cpu_addr = 32'h200; cpu_we = 1; cpu_wdata = 32'h5555_0000;
    dma_req = 1; dma_addr = 32'h80; dma_we = 1; dma_wdata = 32'hA5A5_A5A5;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("ct_bus_we", {31'b0, bus_we}, 1);
      chk("ct_bus_addr", bus_addr, 32'h200);
      chk("ct_gnt", {31'b0, dma_gnt}, 0);
      chk("ct_ack", {31'b0, dma_ack}, 0);
      step;
    end
    cpu_req = 0; cpu_we = 0;
    #1;
    chk("ct_gnt5", {31'b0, dma_gnt}, 1);
    chk("ct_bus_addr5", bus_addr, 32'h80);
    chk("ct_starve", {31'b0, dma_starve}, 1);
    step;
    chk("ct_ack6", {31'b0, dma_ack}, 1);
    chk("ct_err6", {31'b0, dma_err}, 0);
    chk("ct_mem", mem[32'h80 >> 2], 32'hA5A5_A5A5);
    chk("ct_rdata_keep", dma_rdata, 32'h1234_5678);
    chk("ct_cnt", {16'b0, gnt_cnt}, 2);
    dma_req = 0;
    step;
    chk("ct_starve_clr", {31'b0, dma_starve}, 0);
    cpu_req = 1; cpu_addr = 32'h300;
    dma_req = 1; dma_addr = 32'hFFFC; dma_we = 0;
    step; step;
    chk("sv_starve_2", {31'b0, dma_starve}, 0);
    step; step;
    chk("sv_starve_4", {31'b0, dma_starve}, 1);
    step; step;
    chk("sv_starve_6", {31'b0, dma_starve}, 1);
    cpu_req = 0;
    step;
    chk("sv_ack", {31'b0, dma_ack}, 1);
    chk("sv_rdata", dma_rdata, 32'h0BAD_F00D);
    chk("sv_cnt", {16'b0, gnt_cnt}, 3);
    dma_req = 0;
    step;
    chk("sv_starve_clr", {31'b0, dma_starve}, 0);
    cpu_req = 1; cpu_addr = 32'h300; cpu_we = 0;
    dma_req = 1; dma_addr = 32'h8010_0000; dma_we = 1; dma_wdata = 32'h1111_1111;
    #1;
    chk("we_gnt", {31'b0, dma_gnt}, 0);
    chk("we_bus_we", {31'b0, bus_we}, 0);
    step;
    chk("we_ack", {31'b0, dma_ack}, 1);
    chk("we_err", {31'b0, dma_err}, 1);
    chk("we_cnt", {16'b0, gnt_cnt}, 3);
    chk("we_rdata", dma_rdata, 32'h0BAD_F00D);
    chk("we_mem", mem[0], 0);
    dma_req = 0; cpu_req = 0;
    step;
    chk("we_err_clr", {31'b0, dma_err}, 0);
    dma_req = 1; dma_addr = 32'h0001_0000; dma_we = 0;
    #1;
    chk("hi_gnt", {31'b0, dma_gnt}, 0);
    step;
    chk("hi_err", {31'b0, dma_err}, 1);
    chk("hi_cnt", {16'b0, gnt_cnt}, 3);
    dma_req = 0;
    step;
    cpu_req = 1;
    dma_req = 1; dma_addr = 32'h40; dma_we = 0;
    for (int i = 0; i < 5; i++) step;
    chk("rw_starve", {31'b0, dma_starve}, 1);
    #2 cpu_rst_n = 0;
    #1;
    chk("rw_starve_rst", {31'b0, dma_starve}, 0);
    chk("rw_ack_rst", {31'b0, dma_ack}, 0);
    chk("rw_cnt_rst", {16'b0, gnt_cnt}, 0);
    chk("rw_rdata_rst", dma_rdata, 0);
    cpu_req = 0; dma_req = 0;
    step;
    cpu_rst_n = 1;
    step; step;
    chk("rw_no_ack", {31'b0, dma_ack}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
